// File: rtl/lsu_bank_mem.sv
// Dual-bank (even/odd byte) data memory behind the LSU store decoder.
// Performs byte writes, and returns one-cycle-latency sign/zero-extended loads after a post-reset clear sweep.
module lsu_bank_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_addr_even_1,
  input  logic [ADDR_W-1:0] i_addr_even_2,
  input  logic [ADDR_W-1:0] i_addr_odd_1,
  input  logic [ADDR_W-1:0] i_addr_odd_2,
  input  logic [7:0]        i_data_even_1,
  input  logic [7:0]        i_data_even_2,
  input  logic [7:0]        i_data_odd_1,
  input  logic [7:0]        i_data_odd_2,
  input  logic              i_we_even_1,
  input  logic              i_we_even_2,
  input  logic              i_we_odd_1,
  input  logic              i_we_odd_2,
  input  logic              i_lsu_rden,
  input  logic              i_addr_lsb,
  input  logic [2:0]        i_bmask,
  input  logic              i_ld_un,
  output logic [31:0]       o_ld_data,
  output logic              o_ld_valid,
  output logic              o_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-2:0] cnt, cnt_nxt;

  logic [7:0] mem_even [DEPTH];
  logic [7:0] mem_odd  [DEPTH];

  logic              clearing, ld_issue;
  logic              we_e1, we_e2, we_o1, we_o2;
  logic [ADDR_W-1:0] wa_e1, wa_e2, wa_o1, wa_o2;
  logic [7:0]        wd_e1, wd_e2, wd_o1, wd_o2;

  logic [7:0] rd_e1, rd_e2, rd_o1, rd_o2;
  logic       ld_lsb, ld_un;
  logic [2:0] ld_bmask;
  logic [7:0] b0, b1, b2, b3;
  logic [31:0] ld_result;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = READY;
      end
      READY: state_nxt = READY;
      default: state_nxt = CLEAR;
    endcase
  end

  assign clearing = (state == CLEAR);
  assign o_ready  = (state == READY);
  assign ld_issue = o_ready && i_lsu_rden;

  // During the sweep, port _1 covers the lower half of each bank and port _2 the upper half.
  always_comb begin
    we_e1 = clearing | (o_ready & i_we_even_1);
    we_e2 = clearing | (o_ready & i_we_even_2);
    we_o1 = clearing | (o_ready & i_we_odd_1);
    we_o2 = clearing | (o_ready & i_we_odd_2);
    wa_e1 = clearing ? {1'b0, cnt} : i_addr_even_1;
    wa_e2 = clearing ? {1'b1, cnt} : i_addr_even_2;
    wa_o1 = clearing ? {1'b0, cnt} : i_addr_odd_1;
    wa_o2 = clearing ? {1'b1, cnt} : i_addr_odd_2;
    wd_e1 = clearing ? '0 : i_data_even_1;
    wd_e2 = clearing ? '0 : i_data_even_2;
    wd_o1 = clearing ? '0 : i_data_odd_1;
    wd_o2 = clearing ? '0 : i_data_odd_2;
  end

  // ---------------- banks ----------------
  // Port _2 write follows port _1 so it wins on a same-slot conflict; reads see pre-write data.
  always_ff @(posedge i_clk) begin
    if (we_e1) mem_even[wa_e1] <= wd_e1;
    if (we_e2) mem_even[wa_e2] <= wd_e2;
    if (ld_issue) begin
      rd_e1 <= mem_even[i_addr_even_1];
      rd_e2 <= mem_even[i_addr_even_2];
    end
  end

  always_ff @(posedge i_clk) begin
    if (we_o1) mem_odd[wa_o1] <= wd_o1;
    if (we_o2) mem_odd[wa_o2] <= wd_o2;
    if (ld_issue) begin
      rd_o1 <= mem_odd[i_addr_odd_1];
      rd_o2 <= mem_odd[i_addr_odd_2];
    end
  end

  // ---------------- load control ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ld_valid <= 1'b0;
      ld_lsb     <= 1'b0;
      ld_bmask   <= '0;
      ld_un      <= 1'b0;
    end else begin
      o_ld_valid <= ld_issue;
      if (ld_issue) begin
        ld_lsb   <= i_addr_lsb;
        ld_bmask <= i_bmask;
        ld_un    <= i_ld_un;
      end
    end
  end

  // ---------------- lane assembly and extension ----------------
  always_comb begin
    b0 = ld_lsb ? rd_o1 : rd_e1;
    b1 = ld_lsb ? rd_e1 : rd_o1;
    b2 = ld_lsb ? rd_o2 : rd_e2;
    b3 = ld_lsb ? rd_e2 : rd_o2;
    ld_result = '0;
    case (ld_bmask)
      3'b001:  ld_result = {{24{~ld_un & b0[7]}}, b0};
      3'b010:  ld_result = {{16{~ld_un & b1[7]}}, b1, b0};
      3'b100:  ld_result = {b3, b2, b1, b0};
      default: ld_result = '0;
    endcase
  end

  assign o_ld_data = o_ld_valid ? ld_result : '0;

endmodule

// File: doc/lsu_bank_mem.md
# lsu_bank_mem

Dual-bank byte data memory directly downstream of the LSU store decoder. It receives four per-bank-port address/data/write-enable triples: two ports on the even-byte bank and two on the odd-byte bank. It performs the byte writes, and on loads it reads the same four ports, reassembles the byte lanes, and returns sign- or zero-extended load data one cycle later. After reset, a clear sequencer zeroes both banks before the block accepts traffic.

## Interface
- ADDR_W, 10, slot-index width; each bank holds 2^ADDR_W bytes, for a total byte space of 2^(ADDR_W+1).
- i_clk  in  1  sole clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_addr_even_1, i_addr_even_2, i_addr_odd_1, i_addr_odd_2  in  ADDR_W each  slot index per bank port (slot = byte address >> 1).
- i_data_even_1, i_data_even_2, i_data_odd_1, i_data_odd_2  in  8 each  store byte per port.
- i_we_even_1, i_we_even_2, i_we_odd_1, i_we_odd_2  in  1 each  per-port write enable.
- i_lsu_rden  in  1  load request.
- i_addr_lsb  in  1  bit 0 of the load byte address.
- i_bmask  in  3  load size: 001 = byte, 010 = half, 100 = word.
- i_ld_un  in  1  1 = zero-extend, 0 = sign-extend.
- o_ld_data  out  32  assembled load data.
- o_ld_valid  out  1  o_ld_data is valid this cycle.
- o_ready  out  1  clear sequence is done; writes and loads are accepted.

## Operation
- Even bank holds byte address 2k at slot k. Odd bank holds byte address 2k+1 at slot k.
- Each bank is true dual-port: port _1 and port _2 each have a synchronous write and a synchronous read. Reads are read-first: a read of a slot written in the same cycle returns the old byte.
- Write conflict: if _1 and _2 of one bank write the same slot in the same cycle, port _2 data wins.
- FSM states:
  - CLEAR (entered on reset):
    - 9-bit-wide counter cnt (ADDR_W-1 bits) starts at 0.
    - Each cycle, port _1 of both banks writes 0 to slot cnt, and port _2 writes 0 to slot cnt + 2^(ADDR_W-1).
    - At cnt = 2^(ADDR_W-1)-1, the next state is READY.
  - READY: holds until reset.
- While in CLEAR, all external i_we_* and i_lsu_rden are ignored and o_ready = 0.
- Load issue (READY and i_lsu_rden = 1): register i_addr_lsb, i_bmask and i_ld_un, and read all four ports.
- Lane assembly from the registered lsb:
  - lsb = 0: b0 = even_1, b1 = odd_1, b2 = even_2, b3 = odd_2.
  - lsb = 1: b0 = odd_1, b1 = even_1, b2 = odd_2, b3 = even_2.
- Size and extension:
  - byte: result = extend(b0).
  - half: result = extend({b1, b0}).
  - word: result = {b3, b2, b1, b0}.
  - Any other bmask value: result = 0 with o_ld_valid = 1.
  - Extension fills with the top data bit when i_ld_un = 0, and with zeros otherwise.
- Address arithmetic is done upstream and wraps modulo 2^ADDR_W. This block treats every slot index as-is, with no bounds check.
- Stores and a load may be issued in the same cycle. The load sees pre-store data.

## Timing
- Reset values:
  - o_ld_valid = 0 and o_ld_data = 0 (asynchronous).
  - o_ready = 0.
  - FSM = CLEAR, cnt = 0.
  - Bank contents are not reset directly; the CLEAR sweep zeroes them.
- Clear duration is exactly 2^(ADDR_W-1) cycles (512 at the default): o_ready goes high on the 512th rising edge after reset deassertion.
- Load latency is 1:
  - A request sampled at edge N gives o_ld_valid = 1 and final o_ld_data during cycle N+1.
  - Back-to-back loads are sustained every cycle.
- o_ld_valid is 0 in any cycle that does not follow an accepted request. o_ld_data = 0 whenever o_ld_valid = 0.
- A write sampled at edge N is visible to a load issued at edge N+1 or later.
- Reset asserted mid-CLEAR restarts the sweep from cnt = 0.
- Reset asserted while a load is outstanding forces o_ld_valid = 0 immediately; the load is dropped.

## Test plan
- Clear: release reset and count edges. o_ready rises on exactly the 512th edge. A word load at slot 0x3FF then returns 0x00000000 with valid one cycle later. A load requested during CLEAR yields no valid.
- Aligned word: write even_1 slot 8 = 0x21, odd_1 slot 8 = 0x43, even_2 slot 9 = 0x65, odd_2 slot 9 = 0x87. A load with lsb = 0, bmask = 100 on the same slots returns 0x87654321 on the next cycle.
- Byte extension: with ports addressing the byte at 0x013 (odd_1 slot 9, lsb = 1, bmask = 001), i_ld_un = 0 returns 0xFFFFFF87 and i_ld_un = 1 returns 0x00000087.
- Misaligned half: lsb = 1, odd_1 slot 8, even_1 slot 9, bmask = 010, i_ld_un = 0 returns 0x00006543.
- Read-during-write:
  - Same cycle: write 0xAA to even_1 slot 8 and load lsb = 0, bmask = 001 from slot 8. Returns 0x00000021 (pre-store data).
  - Following cycle: the same load returns 0xFFFFFFAA.
  - Port conflict: even_1 and even_2 both write slot 4 (0x11 and 0x22). A later read returns 0x22.
- Reset mid-operation:
  - Asserting reset at CLEAR cycle 100 holds o_ready at 0; after release, o_ready rises 512 edges later.
  - Asserting reset in the cycle after a load request drops o_ld_valid to 0 asynchronously.
